// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC memory-side blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package npc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_LS = 2'd2
  } arb_state_e;

  localparam logic MID_IF = 1'b0;
  localparam logic MID_LS = 1'b1;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both master request/response channels plus the shared memory port.
// Latency: n/a (wires only).
// Backpressure: valid/ready on requests; responses are single-cycle strobes that are always accepted.
interface mem_arbiter_if #(
  parameter int AW = 32
) ();

  logic          if_req_valid;
  logic          if_req_ready;
  logic [AW-1:0] if_addr;
  logic          if_rsp_valid;
  logic [31:0]   if_rdata;
  logic          if_rsp_err;

  logic          ls_req_valid;
  logic          ls_req_ready;
  logic [AW-1:0] ls_addr;
  logic          ls_wen;
  logic [31:0]   ls_wdata;
  logic [3:0]    ls_wmask;
  logic          ls_rsp_valid;
  logic [31:0]   ls_rdata;
  logic          ls_rsp_err;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_wen;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_rsp_valid;
  logic [31:0]   mem_rdata;

  // Arbiter side: serves the two masters and drives the memory request.
  modport slave (
    input  if_req_valid, if_addr,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
    output ls_req_ready, ls_rsp_valid, ls_rdata, ls_rsp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  // Environment side: the two masters and the memory model.
  modport master (
    output if_req_valid, if_addr,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  if_req_ready, if_rsp_valid, if_rdata, if_rsp_err,
    input  ls_req_ready, ls_rsp_valid, ls_rdata, ls_rsp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Saturating response watchdog; expire is high while the count sits at TIMEOUT-1.
// Latency: clear takes effect on the next cycle; expire is combinational from the count.
// Backpressure: none.
module watchdog_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  localparam logic [W-1:0] SAT  = W'(TIMEOUT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stop at TIMEOUT.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != SAT)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU and LSU, one transaction in flight.
// Latency: request and response pass through combinationally (0 cycles); timeout TIMEOUT cycles after handshake.
// Backpressure: mem_req_ready goes to the selected master only; nothing is accepted while waiting.
module mem_arbiter
  import npc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int AW      = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output logic         stray_rsp
);

  arb_state_e    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          stray_q, stray_d;
  logic          sel_ls;
  logic          req_any;
  logic          wd_clr, wd_en, wd_expire;
  logic [AW-1:0] addr_sel;

  watchdog_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Request mux, ready steering, response routing and next-state selection.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    stray_d      = (state_q == IDLE) && bus.mem_rsp_valid;
    wd_clr       = 1'b0;
    wd_en        = 1'b0;
    addr_sel     = '0;
    // LSU wins when alone, or on a tie when the IFU had the previous grant.
    sel_ls  = bus.ls_req_valid && (!bus.if_req_valid || (last_grant_q == MID_IF));
    req_any = bus.if_req_valid || bus.ls_req_valid;

    bus.if_req_ready  = 1'b0;
    bus.ls_req_ready  = 1'b0;
    bus.if_rsp_valid  = 1'b0;
    bus.if_rdata      = '0;
    bus.if_rsp_err    = 1'b0;
    bus.ls_rsp_valid  = 1'b0;
    bus.ls_rdata      = '0;
    bus.ls_rsp_err    = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_wen       = 1'b0;
    bus.mem_wdata     = '0;
    bus.mem_wmask     = '0;

    unique case (state_q)
      IDLE: begin
        bus.mem_req_valid = req_any;
        if (sel_ls) begin
          addr_sel         = bus.ls_addr;
          bus.mem_wen      = bus.ls_wen;
          bus.mem_wdata    = bus.ls_wdata;
          bus.mem_wmask    = bus.ls_wmask;
          bus.ls_req_ready = bus.mem_req_ready;
        end else begin
          // IFU fetches are reads, so write fields stay zero.
          addr_sel         = bus.if_addr;
          bus.if_req_ready = bus.if_req_valid && bus.mem_req_ready;
        end
        if (req_any && bus.mem_req_ready) begin
          state_d      = sel_ls ? WAIT_LS : WAIT_IF;
          last_grant_d = sel_ls ? MID_LS : MID_IF;
          wd_clr       = 1'b1;
        end
      end
      WAIT_IF: begin
        wd_en = 1'b1;
        // A real response on the expiry cycle beats the timeout.
        if (bus.mem_rsp_valid) begin
          bus.if_rsp_valid = 1'b1;
          bus.if_rdata     = bus.mem_rdata;
          state_d          = IDLE;
        end else if (wd_expire) begin
          bus.if_rsp_valid = 1'b1;
          bus.if_rsp_err   = 1'b1;
          state_d          = IDLE;
        end
      end
      WAIT_LS: begin
        wd_en = 1'b1;
        if (bus.mem_rsp_valid) begin
          bus.ls_rsp_valid = 1'b1;
          bus.ls_rdata     = bus.mem_rdata;
          state_d          = IDLE;
        end else if (wd_expire) begin
          bus.ls_rsp_valid = 1'b1;
          bus.ls_rsp_err   = 1'b1;
          state_d          = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_addr = addr_sel;

  // State, round-robin history and stray-response flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= MID_IF;
      stray_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      stray_q      <= stray_d;
    end
  end

  assign stray_rsp = stray_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table plus randomized traffic, all checked against a transaction-level model.
// Latency: n/a.
// Backpressure: masters hold requests until ready; memory ready/response are randomized.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stray_rsp;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32)) bus ();

  mem_arbiter #(
    .TIMEOUT (TO),
    .AW      (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .stray_rsp (stray_rsp)
  );

  typedef struct packed {
    logic        mem_rv;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        if_rdy;
    logic        ls_rdy;
    logic        if_rv;
    logic        if_err;
    logic [31:0] if_rdata;
    logic        ls_rv;
    logic        ls_err;
    logic [31:0] ls_rdata;
    logic        stray;
  } out_t;

  // inputs and expected {mem_rv, if_rdy, ls_rdy, if_rv, ls_rv, err, stray}
  typedef struct {
    logic       rst_n;
    logic       ifv;
    logic       lsv;
    logic       mrdy;
    logic       mrsp;
    logic [6:0] exp;
  } vec_t;

  int vectors = 0;
  int misc = 0;

  // transaction-level reference: who owns the port and how long since the handshake
  int owner = -1;
  int age = 0;
  bit prefer_ls = 1'b1;
  bit stray_m = 1'b0;

  logic acc_if, acc_ls;

  function automatic int pick();
    if (bus.if_req_valid && bus.ls_req_valid) return prefer_ls ? 1 : 0;
    if (bus.ls_req_valid) return 1;
    return 0;
  endfunction

  function automatic out_t sample();
    out_t a;
    a.mem_rv    = bus.mem_req_valid;
    a.mem_addr  = bus.mem_addr;
    a.mem_wen   = bus.mem_wen;
    a.mem_wdata = bus.mem_wdata;
    a.mem_wmask = bus.mem_wmask;
    a.if_rdy    = bus.if_req_ready;
    a.ls_rdy    = bus.ls_req_ready;
    a.if_rv     = bus.if_rsp_valid;
    a.if_err    = bus.if_rsp_err;
    a.if_rdata  = bus.if_rdata;
    a.ls_rv     = bus.ls_rsp_valid;
    a.ls_err    = bus.ls_rsp_err;
    a.ls_rdata  = bus.ls_rdata;
    a.stray     = stray_rsp;
    return a;
  endfunction

  function automatic out_t model_out();
    out_t e;
    logic [31:0] d;
    logic err;
    e = '0;
    e.stray = stray_m;
    if (owner < 0) begin
      e.mem_rv = bus.if_req_valid | bus.ls_req_valid;
      if (pick() == 1) begin
        e.mem_addr  = bus.ls_addr;
        e.mem_wen   = bus.ls_wen;
        e.mem_wdata = bus.ls_wdata;
        e.mem_wmask = bus.ls_wmask;
        e.ls_rdy    = bus.mem_req_ready;
      end else begin
        e.mem_addr = bus.if_addr;
        e.if_rdy   = bus.if_req_valid & bus.mem_req_ready;
      end
    end else if (bus.mem_rsp_valid || age == TO) begin
      err = !bus.mem_rsp_valid;
      d   = bus.mem_rsp_valid ? bus.mem_rdata : 32'h0;
      if (owner == 0) begin
        e.if_rv = 1'b1; e.if_err = err; e.if_rdata = d;
      end else begin
        e.ls_rv = 1'b1; e.ls_err = err; e.ls_rdata = d;
      end
    end
    return e;
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      owner = -1; age = 0; prefer_ls = 1'b1; stray_m = 1'b0;
    end else begin
      stray_m = (owner < 0) && bus.mem_rsp_valid;
      if (owner < 0) begin
        if ((bus.if_req_valid || bus.ls_req_valid) && bus.mem_req_ready) begin
          owner = pick();
          age = 1;
          prefer_ls = (owner == 0);
        end
      end else if (bus.mem_rsp_valid || age == TO) begin
        owner = -1;
      end else begin
        age++;
      end
    end
  endtask

  // Inputs are already driven (posedge+1); compare mid-cycle, then advance the model and the clock.
  task automatic step(input string name, input bit use_tbl, input logic [6:0] exp);
    out_t a, e;
    logic [6:0] got;
    #4;
    a = sample();
    e = model_out();
    acc_if = a.if_rdy;
    acc_ls = a.ls_rdy;
    vectors++;
    if (a !== e) begin
      misc++;
      $display("FAIL %s model: got %h want %h", name, a, e);
    end
    if (use_tbl) begin
      got = {a.mem_rv, a.if_rdy, a.ls_rdy, a.if_rv, a.ls_rv, a.if_err | a.ls_err, a.stray};
      vectors++;
      if (got !== exp) begin
        misc++;
        $display("FAIL %s table: got %b want %b", name, got, exp);
      end
    end
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  vec_t tbl[29];
  bit if_pend, ls_pend;

  initial begin
    // arbitration after reset, alternation
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1010000};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000100};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1100000};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0001000};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1010000};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000100};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1100000};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 7'b0001000};
    // LSU timeout, then late response counted as stray
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'b1010000};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000110};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0000000};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001};
    // response lands on the expiry cycle
    tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1100000};
    tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7'b0001000};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    // memory stall, then reset while waiting on the IFU
    tbl[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1000000};
    tbl[23] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1100000};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    tbl[25] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 7'b1000000};
    tbl[26] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'b0000001};
    tbl[27] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 7'b1010000};
    tbl[28] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0000100};

    bus.if_req_valid  = 1'b0;
    bus.if_addr       = 32'h8000_0000;
    bus.ls_req_valid  = 1'b0;
    bus.ls_addr       = 32'h8000_0100;
    bus.ls_wen        = 1'b1;
    bus.ls_wdata      = 32'hDEAD_BEEF;
    bus.ls_wmask      = 4'b0011;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0000_0413;
    rst_n = 1'b0;
    model_update();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 29; i++) begin
      rst_n             = tbl[i].rst_n;
      bus.if_req_valid  = tbl[i].ifv;
      bus.ls_req_valid  = tbl[i].lsv;
      bus.mem_req_ready = tbl[i].mrdy;
      bus.mem_rsp_valid = tbl[i].mrsp;
      step($sformatf("tbl[%0d]", i), 1'b1, tbl[i].exp);
    end

    // LSU store: exact request fields at the handshake
    rst_n = 1'b1;
    bus.if_req_valid  = 1'b0;
    bus.ls_req_valid  = 1'b1;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    #2;
    chk("store_addr", bus.mem_addr, 32'h8000_0100);
    chk("store_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    chk("store_wmask", {28'h0, bus.mem_wmask}, 32'h3);
    chk("store_wen", {31'h0, bus.mem_wen}, 32'h1);
    step("store_req", 1'b0, 7'h0);
    bus.ls_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    step("store_rsp", 1'b0, 7'h0);

    // IFU read: write fields zeroed, data routed to the IFU only
    bus.if_req_valid  = 1'b1;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    #2;
    chk("ifu_addr", bus.mem_addr, 32'h8000_0000);
    chk("ifu_wdata", bus.mem_wdata, 32'h0);
    chk("ifu_wmask", {28'h0, bus.mem_wmask}, 32'h0);
    step("ifu_req", 1'b0, 7'h0);
    bus.if_req_valid  = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    #2;
    chk("ifu_rdata", bus.if_rdata, 32'h0000_0413);
    chk("ifu_rsp_valid", {31'h0, bus.if_rsp_valid}, 32'h1);
    chk("ifu_ls_quiet", {31'h0, bus.ls_rsp_valid}, 32'h0);
    step("ifu_rsp", 1'b0, 7'h0);

    // randomized traffic with hold-until-ready masters
    if_pend = 1'b0;
    ls_pend = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        bus.if_addr = $urandom;
      end
      if (!ls_pend && $urandom_range(0, 2) == 0) begin
        ls_pend = 1'b1;
        bus.ls_addr  = $urandom;
        bus.ls_wen   = 1'($urandom_range(0, 1));
        bus.ls_wdata = $urandom;
        bus.ls_wmask = 4'($urandom_range(0, 15));
      end
      bus.if_req_valid  = if_pend;
      bus.ls_req_valid  = ls_pend;
      bus.mem_req_ready = ($urandom_range(0, 3) != 0);
      bus.mem_rsp_valid = ($urandom_range(0, 3) == 0);
      bus.mem_rdata     = $urandom;
      step($sformatf("rand[%0d]", c), 1'b0, 7'h0);
      if (acc_if) if_pend = 1'b0;
      if (acc_ls) ls_pend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the core's single memory port between instruction fetch (IFU) and load/store (LSU) in the multi-cycle NPC. It grants one transaction at a time with round-robin priority, holds ownership until the response returns, and routes the response back to the owner. A watchdog counter ends any transaction that never gets a response by returning an error response.

## Interface
- `TIMEOUT`, default 255: cycles spent waiting for a response before the block forces an error response. Must be ≥1.
- `AW`, default 32: address width.
- `clk`  in  1  clock. The block uses one clock; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `if_req_valid`, `ls_req_valid`  in  1  request pending from IFU / LSU.
- `if_req_ready`, `ls_req_ready`  out  1  request accepted this cycle.
- `if_addr`, `ls_addr`  in  AW  request address.
- `ls_wen`  in  1  LSU write (1) or read (0). IFU requests are always reads.
- `ls_wdata`  in  32  write data. `ls_wmask`  in  4  byte mask.
- `if_rsp_valid`, `ls_rsp_valid`  out  1  one-cycle response strobe. Masters always accept it.
- `if_rdata`, `ls_rdata`  out  32  read data; must be 0 when the matching rsp_valid is 0.
- `if_rsp_err`, `ls_rsp_err`  out  1  timeout error; valid only together with rsp_valid.
- `mem_req_valid`  out  1. `mem_req_ready`  in  1.
- `mem_addr`  out  AW. `mem_wen`  out  1. `mem_wdata`  out  32. `mem_wmask`  out  4.
- `mem_rsp_valid`  in  1. `mem_rdata`  in  32.
- `stray_rsp`  out  1  registered pulse raised when a `mem_rsp_valid` arrives while the block is not waiting for one.

## Operation
- FSM states:
  - IDLE: accepts and forwards requests.
  - WAIT_IF / WAIT_LS: a transaction is outstanding for that master.
- Selection in IDLE:
  - If only one `*_req_valid` is high, that master is selected.
  - If both are high, the master not granted last time wins (`last_grant` register).
- Request forwarding in IDLE:
  - `mem_req_valid = if_req_valid | ls_req_valid`.
  - The mem_* request fields come from the selected master, combinationally. For IFU: `mem_wen=0`, `mem_wdata=0`, `mem_wmask=0`.
  - The selected master's ready equals `mem_req_ready`. The other master's ready is 0.
- Handshake (`mem_req_valid & mem_req_ready`): go to WAIT_IF or WAIT_LS, update `last_grant`, clear the watchdog counter.
- In WAIT_*:
  - `mem_req_valid=0` and both readies are 0.
  - The counter increments every cycle.
- Response in WAIT_x:
  - On `mem_rsp_valid`, drive `x_rsp_valid=1` and `x_rdata=mem_rdata` combinationally in the same cycle, with `x_rsp_err=0`.
  - Next state is IDLE.
- Timeout:
  - If the counter equals `TIMEOUT-1` and `mem_rsp_valid=0`, drive `x_rsp_valid=1`, `x_rsp_err=1`, `x_rdata=0`.
  - Next state is IDLE.
- Response and timeout in the same cycle: the response wins, with no error.
- Any `mem_rsp_valid` in IDLE is dropped and `stray_rsp` pulses on the next cycle. This covers late responses after a timeout.
- Master-side requests are assumed stable until ready. The block does not check this.
- Counter width: `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Timing
- Reset values:
  - State IDLE, `last_grant`=IF (so the LSU wins the first tie), counter 0, `stray_rsp` 0.
  - All outputs are 0 except combinational pass-through while IDLE.
- Reset during WAIT_* abandons the transaction. The later response counts as stray.
- Grant latency: 0 cycles (the request reaches memory in the same cycle).
- Response latency: 0 cycles from `mem_rsp_valid`.
- Back-to-back transactions:
  - A new request can be accepted on the cycle after the response, giving a minimum 2 cycles per transaction when memory responds on the cycle after acceptance.
  - A request can never be accepted in the same cycle as a response.
- Timeout fires exactly `TIMEOUT` cycles after the handshake cycle.

## Structure
- Shared package `npc_pkg`:
  - State enum {IDLE, WAIT_IF, WAIT_LS}.
  - Master-id constants MID_IF=0, MID_LS=1.
  - Default `TIMEOUT` constant.
- One sub-module, `watchdog_cnt`, with clear/enable/expire ports and a `TIMEOUT` parameter.
- The request mux and FSM live in this block.

## Test plan
- **Single IFU read:** IFU reads 0x8000_0000, memory ready=1 and returns 0x0000_0413 on the next cycle -> `if_rsp_valid` for 1 cycle with that data; `ls_rsp_valid` stays 0.
- **Simultaneous requests after reset:** both masters request in the same cycle -> LSU granted first. IFU is granted on the first IDLE cycle after the LSU response. When both keep requesting, grants alternate LS, IF, LS, IF.
- **LSU store:** store with wmask=4'b0011 and wdata=0xDEAD_BEEF at 0x8000_0100 -> the mem_* fields match exactly during the handshake, and `mem_wdata`/`mem_wmask` are 0 during IFU grants.
- **Timeout:** TIMEOUT=4 and memory never responds -> `ls_rsp_valid` with err=1 and rdata=0, exactly 4 cycles after the handshake. A later `mem_rsp_valid` produces a `stray_rsp` pulse and no master response.
- **Response on the timeout cycle:** the response arrives on the expiry cycle -> err=0 and data is delivered.
- **Reset mid-transaction:** assert `rst_n=0` during WAIT_IF -> the next cycle is IDLE, both readies follow the reset rules, and no response is delivered.
